uart_temp_formatter: RTL and testbench
======================================

Name: uart_temp_formatter

Overview:
Sequences the UART transmitter for the LTC2986 temperature monitor.
- Accepts one signed temperature sample plus channel number over a valid/ready handshake.
- Converts the magnitude to BCD with a sequential double-dabble.
- Feeds the 12-byte ASCII frame "Cn:sdddd.d\r\n" to the UART TX one byte at a time, using the transmitter's state output as the byte handshake.
- Sits between the LTC2986 SPI readout logic and the UART TX.

Parameters:
- CH_W, 3, width of channel number. Channel is printed as a single ASCII digit, so CH_W is at most 3.
- DP_EN, 1, 1 inserts '.' before the last digit, giving a 12-byte frame. 0 omits it, giving an 11-byte frame.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- temp_valid  in  1  sample request
- temp_ready  out  1  high only in IDLE; the sample is accepted on the cycle temp_valid && temp_ready
- temp_data  in  16  signed two's-complement temperature, units 0.1 degC
- temp_ch  in  CH_W  channel number
- uart_start  out  1  start request to the UART TX
- uart_data  out  8  byte to the UART TX
- ust_state  in  3  UART TX state: 0 = idle, nonzero = busy
- busy  out  1  high from sample acceptance until frame end
- frame_done  out  1  one-cycle pulse after the last byte's stop bit ends

Behaviour:
- Reset values:
  - temp_ready = 1, uart_start = 0, uart_data = 8'h00, busy = 0, frame_done = 0.
  - FSM goes to IDLE; byte index = 0.
  - Reset mid-frame aborts immediately. The partial frame is not resumed.
- IDLE:
  - On accept, latch channel, sign (temp_data[15]) and magnitude. Magnitude is 0 - temp_data when negative, as 16-bit unsigned, so -32768 gives 32768.
  - Next state CONVERT; busy = 1, temp_ready = 0.
- CONVERT:
  - Double-dabble over 16 bits, exactly 16 cycles.
  - Result is 5 BCD digits d4..d0. Then go to LOAD.
- LOAD:
  - Drive uart_data from the byte index.
  - Byte order: 'C', '0'+ch, ':', sign, d4, d3, d2, d1, '.' (only if DP_EN), d0, 8'h0D, 8'h0A.
  - Sign is '+' for zero and positive values, '-' for negative values.
  - Digits are 8'h30 + BCD. Leading zeros are printed.
  - Next state SEND.
- SEND:
  - Assert uart_start only when ust_state == 0.
  - Hold uart_start and uart_data stable until ust_state != 0 is sampled.
  - On that cycle, drop uart_start (registered, so low on the next cycle) and go to WAIT_DONE.
  - uart_start may be high for at most one cycle while ust_state != 0. This is harmless because the TX ignores start outside state 0.
- WAIT_DONE:
  - Wait for ust_state == 0.
  - If this was the last byte (index FRAME_LEN-1): pulse frame_done, clear busy, set temp_ready, go to IDLE.
  - Otherwise: increment the index and go to LOAD.
- uart_data stays stable from LOAD through WAIT_DONE.
- Exactly one uart_start acceptance per byte; no byte is skipped or duplicated.
- temp_valid while busy: ignored (not latched). The requester holds it until temp_ready.
- Latency: sample accept to first uart_start = 18 cycles (1 latch + 16 convert + 1 load).
- ust_state stuck nonzero: the FSM waits indefinitely. There is no timeout.

Decomposition:
- Package uart_fmt_pkg:
  - FSM state encoding (IDLE, CONVERT, LOAD, SEND, WAIT_DONE).
  - ASCII constants: 'C', ':', '+', '-', '.', '0', CR, LF.
  - FRAME_LEN function of DP_EN (12 or 11).
  - UST_IDLE = 3'd0.
- Sub-module bin2bcd_seq:
  - Inputs: start pulse and 16-bit unsigned value.
  - Runs 16-cycle shift/add-3.
  - Outputs: done pulse and 20-bit BCD.
  - Same clk/reset.

Test Plan:
- temp_data = 16'd253, ch = 2, with a behavioural UART TX model (104 clk/bit) -> serial bytes "C2:+0025.3\r\n", 12 uart_start acceptances, one frame_done.
- temp_data = 16'h8000 (-32768), ch = 7 -> "C7:-3276.8\r\n"; temp_data = 0, ch = 0 -> "C0:+0000.0\r\n".
- DP_EN = 0, temp_data = -1, ch = 1 -> 11 bytes "C1:-00001\r\n".
- Second temp_valid raised during a frame -> temp_ready stays 0 and no latch. The second sample is accepted on the cycle after frame_done, with its first uart_start 18 cycles after acceptance.
- Reset asserted during byte 5 -> uart_start = 0, busy = 0, temp_ready = 1 immediately. The next sample produces a complete fresh frame starting at 'C'.
- ust_state model delays leaving 0 by 3 cycles -> uart_start is held high and uart_data is stable for those cycles, with a single acceptance.

Source files
------------

// File: rtl/uart_fmt_pkg.sv
// Shared types and constants for the LTC2986 temperature-to-UART frame formatter.
// Frame layout: "Cn:sdddd.d\r\n" (the '.' is optional).
package uart_fmt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_DONE
    } fmt_state_t;

    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam logic [2:0] UST_IDLE   = 3'd0;
    localparam int         BIN_W      = 16;
    localparam int         BCD_DIGITS = 5;

    function automatic int frame_len(input int dp_en);
        return (dp_en != 0) ? 12 : 11;
    endfunction

endpackage

// File: rtl/uart_temp_formatter_if.sv
// Sample-side and UART-side signals of the temperature formatter.
// slave = the formatter's view, master = the surrounding logic's view.
interface uart_temp_formatter_if #(
    parameter int CH_W = 3
);
    logic            temp_valid;
    logic            temp_ready;
    logic [15:0]     temp_data;
    logic [CH_W-1:0] temp_ch;
    logic            uart_start;
    logic [7:0]      uart_data;
    logic [2:0]      ust_state;
    logic            busy;
    logic            frame_done;

    modport slave (
        input  temp_valid, temp_data, temp_ch, ust_state,
        output temp_ready, uart_start, uart_data, busy, frame_done
    );

    modport master (
        output temp_valid, temp_data, temp_ch, ust_state,
        input  temp_ready, uart_start, uart_data, busy, frame_done
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit unsigned to 5 BCD digits in 16 cycles.
// bcd holds the result after done until the next start.
module bin2bcd_seq
    import uart_fmt_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);
    logic [BIN_W-1:0]        shift_reg;
    logic [4*BCD_DIGITS-1:0] bcd_reg;
    logic [4:0]              cnt_reg;
    logic                    done_reg;
    logic [4*BCD_DIGITS-1:0] bcd_adj;

    // Add-3 correction on every digit that would overflow past 9 when doubled.
    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_add3
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 :
                                        bcd_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                shift_reg <= bin;
                bcd_reg   <= '0;
                cnt_reg   <= 5'd16;
            end else if (cnt_reg != 5'd0) begin
                {bcd_reg, shift_reg} <= {bcd_adj[4*BCD_DIGITS-2:0], shift_reg, 1'b0};
                cnt_reg <= cnt_reg - 5'd1;
                if (cnt_reg == 5'd1) begin
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign done = done_reg;
    assign bcd  = bcd_reg;

endmodule

// File: rtl/uart_temp_formatter.sv
// Formats one signed 0.1 degC sample as an ASCII line and hands it to the UART TX
// byte by byte, using the TX state (0 = idle) as the per-byte handshake.
module uart_temp_formatter
    import uart_fmt_pkg::*;
#(
    parameter int CH_W  = 3,
    parameter int DP_EN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_temp_formatter_if.slave  bus
);
    localparam int         FRAME_LEN = frame_len(DP_EN);
    localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);

    fmt_state_t      state_reg;
    logic [CH_W-1:0] ch_reg;
    logic            neg_reg;
    logic [3:0]      idx_reg;
    logic            temp_ready_reg;
    logic            uart_start_reg;
    logic [7:0]      uart_data_reg;
    logic            busy_reg;
    logic            frame_done_reg;

    logic            accept;
    logic [15:0]     magnitude;
    logic            bcd_done;
    logic [19:0]     bcd;
    logic [7:0]      digit_ascii [BCD_DIGITS];
    logic [7:0]      frame_byte;

    assign accept    = (state_reg == ST_IDLE) && bus.temp_valid && temp_ready_reg;
    // 0 - x in 16 bits maps -32768 onto 32768 without overflow.
    assign magnitude = bus.temp_data[15] ? (16'd0 - bus.temp_data) : bus.temp_data;

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .bin   (magnitude),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            assign digit_ascii[gi] = ASCII_0 + {4'b0000, bcd[gi*4 +: 4]};
        end
    endgenerate

    always_comb begin
        frame_byte = ASCII_LF;
        case (idx_reg)
            4'd0:    frame_byte = ASCII_C;
            4'd1:    frame_byte = ASCII_0 + 8'(ch_reg);
            4'd2:    frame_byte = ASCII_COLON;
            4'd3:    frame_byte = neg_reg ? ASCII_MINUS : ASCII_PLUS;
            4'd4:    frame_byte = digit_ascii[4];
            4'd5:    frame_byte = digit_ascii[3];
            4'd6:    frame_byte = digit_ascii[2];
            4'd7:    frame_byte = digit_ascii[1];
            4'd8:    frame_byte = (DP_EN != 0) ? ASCII_DOT : digit_ascii[0];
            4'd9:    frame_byte = (DP_EN != 0) ? digit_ascii[0] : ASCII_CR;
            4'd10:   frame_byte = (DP_EN != 0) ? ASCII_CR : ASCII_LF;
            default: frame_byte = ASCII_LF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            ch_reg         <= '0;
            neg_reg        <= 1'b0;
            idx_reg        <= 4'd0;
            temp_ready_reg <= 1'b1;
            uart_start_reg <= 1'b0;
            uart_data_reg  <= 8'h00;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        ch_reg         <= bus.temp_ch;
                        neg_reg        <= bus.temp_data[15];
                        idx_reg        <= 4'd0;
                        busy_reg       <= 1'b1;
                        temp_ready_reg <= 1'b0;
                        state_reg      <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    if (bcd_done) begin
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    uart_data_reg  <= frame_byte;
                    uart_start_reg <= (bus.ust_state == UST_IDLE);
                    state_reg      <= ST_SEND;
                end
                ST_SEND: begin
                    // A busy TX only counts as acceptance if we were already requesting;
                    // otherwise it is still finishing something else (e.g. after an abort).
                    if (uart_start_reg && (bus.ust_state != UST_IDLE)) begin
                        uart_start_reg <= 1'b0;
                        state_reg      <= ST_WAIT_DONE;
                    end else if (bus.ust_state == UST_IDLE) begin
                        uart_start_reg <= 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.ust_state == UST_IDLE) begin
                        if (idx_reg == LAST_IDX) begin
                            frame_done_reg <= 1'b1;
                            busy_reg       <= 1'b0;
                            temp_ready_reg <= 1'b1;
                            idx_reg        <= 4'd0;
                            state_reg      <= ST_IDLE;
                        end else begin
                            idx_reg   <= idx_reg + 4'd1;
                            state_reg <= ST_LOAD;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.temp_ready = temp_ready_reg;
    assign bus.uart_start = uart_start_reg;
    assign bus.uart_data  = uart_data_reg;
    assign bus.busy       = busy_reg;
    assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_uart_temp_formatter.sv
// Bench for uart_temp_formatter: a behavioural UART TX model checks each accepted
// byte against a queue of expected frame bytes pushed when a sample is accepted.
module tb_uart_temp_formatter;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  ch;
        logic [79:0] txt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sel;
    logic        t_valid;
    logic [15:0] t_data;
    logic [2:0]  t_ch;
    logic [2:0]  tx_state;

    uart_temp_formatter_if #(.CH_W(3)) bus_a ();
    uart_temp_formatter_if #(.CH_W(3)) bus_b ();

    uart_temp_formatter #(.CH_W(3), .DP_EN(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    uart_temp_formatter #(.CH_W(3), .DP_EN(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    assign bus_a.temp_valid = t_valid & ~sel;
    assign bus_b.temp_valid = t_valid & sel;
    assign bus_a.temp_data  = t_data;
    assign bus_b.temp_data  = t_data;
    assign bus_a.temp_ch    = t_ch;
    assign bus_b.temp_ch    = t_ch;
    assign bus_a.ust_state  = tx_state;
    assign bus_b.ust_state  = tx_state;

    logic       cur_ready, cur_start, cur_busy, cur_done;
    logic [7:0] cur_data;
    assign cur_ready = sel ? bus_b.temp_ready : bus_a.temp_ready;
    assign cur_start = sel ? bus_b.uart_start : bus_a.uart_start;
    assign cur_busy  = sel ? bus_b.busy       : bus_a.busy;
    assign cur_done  = sel ? bus_b.frame_done : bus_a.frame_done;
    assign cur_data  = sel ? bus_b.uart_data  : bus_a.uart_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int c0;
    int bit_clks;
    int tx_delay;
    int acc_total;
    int acc_base;
    int hold_total;
    logic [7:0] exp_q [$];
    vec_t vecs [7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // UART TX model: accepts start in state 0, optionally lingers in 0, then busy 10 bits.
    initial begin : tx_model
        logic       pend;
        logic       prev_done;
        logic [7:0] held;
        int         dly;
        int         busy_cnt;
        tx_state   = 3'd0;
        pend       = 1'b0;
        prev_done  = 1'b0;
        held       = 8'h00;
        dly        = 0;
        busy_cnt   = 0;
        acc_total  = 0;
        hold_total = 0;
        forever begin
            @(negedge clk);
            if (cur_done === 1'b1) check("frame_done_pulse", {31'd0, prev_done}, 0);
            prev_done = cur_done;
            if (tx_state == 3'd0) begin
                if (pend) begin
                    check("start_held", {31'd0, cur_start}, 1);
                    check("data_held", {24'd0, cur_data}, {24'd0, held});
                    hold_total++;
                    if (dly == 1) begin
                        tx_state = 3'd1;
                        busy_cnt = 10 * bit_clks;
                        pend     = 1'b0;
                    end
                    dly--;
                end else if (cur_start === 1'b1) begin
                    acc_total++;
                    held = cur_data;
                    check("byte_expected", {31'd0, exp_q.size() != 0}, 1);
                    if (exp_q.size() != 0) check("byte", {24'd0, cur_data}, {24'd0, exp_q.pop_front()});
                    if (tx_delay == 0) begin
                        tx_state = 3'd1;
                        busy_cnt = 10 * bit_clks;
                    end else begin
                        pend = 1'b1;
                        dly  = tx_delay;
                    end
                end
            end else begin
                check("start_low_while_tx_busy", {31'd0, cur_start}, 0);
                if (cur_busy) check("data_stable", {24'd0, cur_data}, {24'd0, held});
                if (busy_cnt <= 1) tx_state = 3'd0;
                else busy_cnt--;
            end
        end
    end

    task automatic accept_sample(input logic [15:0] d, input logic [2:0] ch);
        int n;
        @(negedge clk);
        t_data  = d;
        t_ch    = ch;
        t_valid = 1'b1;
        n = 0;
        while (!cur_ready && n < 50000) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {31'd0, cur_ready}, 1);
        @(posedge clk);
        @(negedge clk);
        c0 = cyc;
    endtask

    task automatic push_frame(input logic [79:0] txt, input int n);
        acc_base = acc_total;
        for (int i = 0; i < n; i++) exp_q.push_back(txt[8*(n-1-i) +: 8]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic check_latency(input string name);
        int n;
        n = 0;
        while (cur_start !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, cyc - c0, 18);
        check({name, "_busy_flags"}, {30'd0, cur_busy, cur_ready}, 32'd2);
    endtask

    task automatic wait_done(input string name, input int n_bytes);
        int n;
        bit ready_leak;
        n = 0;
        ready_leak = 1'b0;
        while (cur_done !== 1'b1 && n < 40000) begin
            if (cur_ready) ready_leak = 1'b1;
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, {31'd0, cur_done}, 1);
        check({name, "_ready_low"}, {31'd0, ready_leak}, 0);
        check({name, "_bytes"}, acc_total - acc_base, n_bytes);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_idle_flags"}, {30'd0, cur_busy, cur_ready}, 32'd1);
        $display("[TB] frame %s: %0d bytes accepted, done after %0d cycles", name, acc_total - acc_base, cyc - c0);
    endtask

    initial begin : main
        int n;
        int hold_base;
        sel      = 1'b0;
        t_valid  = 1'b0;
        t_data   = 16'd0;
        t_ch     = 3'd0;
        bit_clks = 104;
        tx_delay = 0;
        acc_base = 0;
        reset    = 1'b1;

        vecs[0] = '{data: 16'd253,   ch: 3'd2, txt: "C2:+0025.3"};
        vecs[1] = '{data: 16'h8000,  ch: 3'd7, txt: "C7:-3276.8"};
        vecs[2] = '{data: 16'd0,     ch: 3'd0, txt: "C0:+0000.0"};
        vecs[3] = '{data: 16'd32767, ch: 3'd5, txt: "C5:+3276.7"};
        vecs[4] = '{data: 16'hFFFF,  ch: 3'd3, txt: "C3:-0000.1"};
        vecs[5] = '{data: 16'd9999,  ch: 3'd4, txt: "C4:+0999.9"};
        vecs[6] = '{data: 16'hFF03,  ch: 3'd6, txt: "C6:-0025.3"};

        repeat (3) @(negedge clk);
        check("rst_temp_ready", {31'd0, cur_ready}, 1);
        check("rst_uart_start", {31'd0, cur_start}, 0);
        check("rst_uart_data",  {24'd0, cur_data}, 0);
        check("rst_busy",       {31'd0, cur_busy}, 0);
        check("rst_frame_done", {31'd0, cur_done}, 0);
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            if (v == 1) bit_clks = 4;
            accept_sample(vecs[v].data, vecs[v].ch);
            t_valid = 1'b0;
            push_frame(vecs[v].txt, 10);
            $display("[TB] sample %0d: temp=%0d ch=%0d", v, $signed(vecs[v].data), vecs[v].ch);
            check_latency("vec");
            wait_done("vec", 12);
        end

        // Second sample held valid during a frame: accepted only once the frame ends.
        accept_sample(16'd1234, 3'd3);
        t_data = 16'hFF9C;
        t_ch   = 3'd4;
        push_frame("C3:+0123.4", 10);
        check_latency("b2b_first");
        wait_done("b2b_first", 12);
        @(posedge clk);
        @(negedge clk);
        c0 = cyc;
        t_valid = 1'b0;
        push_frame("C4:-0010.0", 10);
        check_latency("b2b_second");
        wait_done("b2b_second", 12);

        // Reset in the middle of byte 5 aborts the frame.
        accept_sample(16'd777, 3'd1);
        t_valid = 1'b0;
        push_frame("C1:+0077.7", 10);
        n = 0;
        while (acc_total - acc_base < 6 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_byte5", acc_total - acc_base, 6);
        reset = 1'b1;
        #1;
        check("abort_uart_start", {31'd0, cur_start}, 0);
        check("abort_busy",       {31'd0, cur_busy}, 0);
        check("abort_temp_ready", {31'd0, cur_ready}, 1);
        $display("[TB] reset asserted after %0d bytes", acc_total - acc_base);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        n = 0;
        while (tx_state != 3'd0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        accept_sample(16'hFC18, 3'd6);
        t_valid = 1'b0;
        push_frame("C6:-0100.0", 10);
        check_latency("after_abort");
        wait_done("after_abort", 12);

        // TX lingers 3 cycles in state 0 after each start.
        tx_delay  = 3;
        hold_base = hold_total;
        accept_sample(16'd42, 3'd5);
        t_valid = 1'b0;
        push_frame("C5:+0004.2", 10);
        check_latency("delayed");
        wait_done("delayed", 12);
        check("delayed_hold_cycles", hold_total - hold_base, 36);
        tx_delay = 0;

        // 11-byte frame without decimal point.
        sel = 1'b1;
        accept_sample(16'hFFFF, 3'd1);
        t_valid = 1'b0;
        push_frame("C1:-00001", 9);
        check_latency("no_dp");
        wait_done("no_dp", 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
